// File: rtl/controlador_de_senha.sv
// controlador_de_senha: PIN-entry sequencer with confirm/backspace/clear, failure counting and timed lockout.
// Optional inactivity timeout in ENTRY is enabled by defining INACTIVITY_TIMEOUT_EN.
module controlador_de_senha #(
    parameter int PIN_LEN     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tecla_valid,
    input  logic [3:0]                   tecla_value,
    input  logic [4*PIN_LEN-1:0]         pin_ref,
    output logic                         unlock,
    output logic                         fail,
    output logic                         locked,
    output logic                         timeout,
    output logic [$clog2(PIN_LEN+1)-1:0] digit_count
);
    localparam int CW = $clog2(PIN_LEN+1);
    localparam int FW = $clog2(MAX_FAIL+1);
    localparam int LW = $clog2(LOCKOUT_CYC);
    typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} state_t;
    state_t               r_st, w_st;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [4*PIN_LEN-1:0] r_buf, w_buf, w_wr;
    logic [FW-1:0]        r_fails, w_fails, w_fails_inc;
    logic [LW-1:0]        r_lk, w_lk;
    logic                 r_unlock, w_unlock, r_fail, w_fail, r_to, w_to;
    logic                 w_dig, w_a, w_b, w_c;
`ifdef INACTIVITY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    logic [TW-1:0]        r_tmr, w_tmr;
`endif
    assign w_dig = tecla_valid && (tecla_value <= 4'h9);
    assign w_a   = tecla_valid && (tecla_value == 4'hA);
    assign w_b   = tecla_valid && (tecla_value == 4'hB);
    assign w_c   = tecla_valid && (tecla_value == 4'hC);
    assign w_fails_inc = (r_fails == FW'(MAX_FAIL)) ? r_fails : r_fails + 1'b1;
    // Digit k of the entry lands in the nibble that pin_ref uses for digit k (first digit in the MSBs).
    always_comb begin
        w_wr = r_buf;
        for (int i = 0; i < PIN_LEN; i++)
            if (r_cnt == CW'(i)) w_wr[4*(PIN_LEN-1-i) +: 4] = tecla_value;
    end
    always_comb begin
        w_st     = r_st;
        w_cnt    = r_cnt;
        w_buf    = r_buf;
        w_fails  = r_fails;
        w_lk     = '0;
        w_unlock = 1'b0;
        w_fail   = 1'b0;
        w_to     = 1'b0;
`ifdef INACTIVITY_TIMEOUT_EN
        w_tmr    = '0;
`endif
        unique case (r_st)
            IDLE: begin
                if (w_dig) begin
                    w_buf = w_wr;
                    w_cnt = CW'(1);
                    w_st  = ENTRY;
                end
            end
            ENTRY: begin
                if (w_dig) begin
                    w_buf = (r_cnt < CW'(PIN_LEN)) ? w_wr : r_buf;
                    w_cnt = (r_cnt < CW'(PIN_LEN)) ? r_cnt + 1'b1 : r_cnt;
                end else if (w_b) begin
                    w_cnt = r_cnt - 1'b1;
                    w_st  = (r_cnt == CW'(1)) ? IDLE : ENTRY;
                end else if (w_c) begin
                    w_cnt = '0;
                    w_buf = '0;
                    w_st  = IDLE;
                end else if (w_a) begin
                    w_st  = CHECK;
                end
`ifdef INACTIVITY_TIMEOUT_EN
                // Any key event, even an ignored one, restarts the timer and wins over expiry.
                w_tmr = tecla_valid ? '0 : r_tmr + 1'b1;
                if (!tecla_valid && r_tmr == TW'(TIMEOUT_CYC-1)) begin
                    w_tmr = '0;
                    w_cnt = '0;
                    w_buf = '0;
                    w_to  = 1'b1;
                    w_st  = IDLE;
                end
`endif
            end
            CHECK: begin
                w_cnt = '0;
                w_buf = '0;
                if (r_cnt == CW'(PIN_LEN) && r_buf == pin_ref) begin
                    w_unlock = 1'b1;
                    w_fails  = '0;
                    w_st     = IDLE;
                end else begin
                    w_fail  = 1'b1;
                    w_fails = w_fails_inc;
                    w_st    = (w_fails_inc == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
                end
            end
            LOCKOUT: begin
                w_lk = r_lk + 1'b1;
                if (r_lk == LW'(LOCKOUT_CYC-1)) begin
                    w_lk    = '0;
                    w_fails = '0;
                    w_st    = IDLE;
                end
            end
            default: w_st = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st     <= IDLE;
            r_cnt    <= '0;
            r_buf    <= '0;
            r_fails  <= '0;
            r_lk     <= '0;
            r_unlock <= 1'b0;
            r_fail   <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_st     <= w_st;
            r_cnt    <= w_cnt;
            r_buf    <= w_buf;
            r_fails  <= w_fails;
            r_lk     <= w_lk;
            r_unlock <= w_unlock;
            r_fail   <= w_fail;
            r_to     <= w_to;
        end
    end
`ifdef INACTIVITY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tmr <= '0;
        else      r_tmr <= w_tmr;
    end
    assign timeout = r_to;
`else
    assign timeout = r_to & (TIMEOUT_CYC > 0);
`endif
    assign unlock      = r_unlock;
    assign fail        = r_fail;
    assign locked      = (r_st == LOCKOUT);
    assign digit_count = r_cnt;
endmodule

// File: tb/tb_controlador_de_senha.sv
// tb_controlador_de_senha: table-driven vectors plus directed lockout, reset and timeout sequences.
module tb_controlador_de_senha;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tecla_valid = 1'b0;
    logic [3:0]  tecla_value = 4'h0;
    logic [15:0] pin_ref = 16'h1234;
    logic        unlock, fail, locked, timeout;
    logic [2:0]  digit_count;
    int total = 0;
    int bad = 0;

    controlador_de_senha #(.PIN_LEN(4), .MAX_FAIL(3), .LOCKOUT_CYC(50), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .tecla_valid(tecla_valid), .tecla_value(tecla_value),
        .pin_ref(pin_ref), .unlock(unlock), .fail(fail), .locked(locked),
        .timeout(timeout), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] k;
        logic [2:0] cnt;
        logic       u;
        logic       f;
    } vec_t;
    vec_t tab[$];

    task automatic add(input logic v, input logic [3:0] k, input logic [2:0] cnt, input logic u, input logic f);
        vec_t r;
        r.v = v; r.k = k; r.cnt = cnt; r.u = u; r.f = f;
        tab.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] k);
        tecla_valid = v;
        tecla_value = k;
        @(negedge clk);
        tecla_valid = 1'b0;
        tecla_value = 4'h0;
    endtask

    task automatic bad_entry();
        step(1, 4'h1); step(1, 4'h2); step(1, 4'h3); step(1, 4'hA);
        step(0, 4'h0);
    endtask

    task automatic good_entry();
        step(1, 4'h1); step(1, 4'h2); step(1, 4'h3); step(1, 4'h4); step(1, 4'hA);
        step(0, 4'h0);
    endtask

    initial begin
        // wrong full PIN, then correct PIN clears the fail counter
        add(1,4'h1,1,0,0); add(1,4'h2,2,0,0); add(1,4'h3,3,0,0); add(1,4'h5,4,0,0);
        add(1,4'hA,4,0,0); add(0,4'h0,0,0,1); add(0,4'h0,0,0,0);
        add(1,4'h1,1,0,0); add(1,4'h2,2,0,0); add(1,4'h3,3,0,0); add(1,4'h4,4,0,0);
        add(1,4'hA,4,0,0); add(0,4'h0,0,1,0); add(0,4'h0,0,0,0);
        // backspace path
        add(1,4'h1,1,0,0); add(1,4'h2,2,0,0); add(1,4'h9,3,0,0); add(1,4'hB,2,0,0);
        add(1,4'h3,3,0,0); add(1,4'h4,4,0,0); add(1,4'hA,4,0,0); add(0,4'h0,0,1,0);
        add(0,4'h0,0,0,0);
        // fifth digit ignored
        add(1,4'h1,1,0,0); add(1,4'h2,2,0,0); add(1,4'h3,3,0,0); add(1,4'h4,4,0,0);
        add(1,4'h5,4,0,0); add(1,4'hA,4,0,0); add(0,4'h0,0,1,0); add(0,4'h0,0,0,0);
        // clear then confirm in IDLE is ignored
        add(1,4'h1,1,0,0); add(1,4'h2,2,0,0); add(1,4'hC,0,0,0); add(1,4'hA,0,0,0);
        add(0,4'h0,0,0,0); add(0,4'h0,0,0,0);
        // D/E/F and A/B ignored in IDLE, D/E/F ignored in ENTRY, backspace to IDLE
        add(1,4'hD,0,0,0); add(1,4'hE,0,0,0); add(1,4'hF,0,0,0); add(1,4'hB,0,0,0);
        add(1,4'h7,1,0,0); add(1,4'hD,1,0,0); add(1,4'hE,1,0,0); add(1,4'hF,1,0,0);
        add(1,4'hB,0,0,0); add(1,4'hA,0,0,0); add(0,4'h0,0,0,0); add(0,4'h0,0,0,0);

        #1;
        chk("rst_outs", {unlock, fail, locked, timeout}, 4'b0000);
        chk("rst_cnt", digit_count, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tab[i]) begin
            step(tab[i].v, tab[i].k);
            chk($sformatf("vec%0d_cnt", i), digit_count, tab[i].cnt);
            chk($sformatf("vec%0d_puls", i), {unlock, fail, locked, timeout}, {tab[i].u, tab[i].f, 2'b00});
        end

        // three short entries -> lockout rising with the third fail
        for (int r = 0; r < 3; r++) begin
            bad_entry();
            chk($sformatf("lk_fail%0d", r), {unlock, fail, locked}, {2'b01, r == 2});
        end
        for (int c = 2; c <= 50; c++) begin
            step(c == 10, 4'h1);
            chk($sformatf("lk_hold%0d", c), {locked, fail}, 2'b10);
            if (c == 10) chk("lk_key_ignored", digit_count, 3'd0);
        end
        step(1, 4'h1);
        chk("lk_end_key_ignored", {locked, digit_count}, {1'b0, 3'd0});
        bad_entry();
        chk("lk_fail_cnt_cleared", {fail, locked}, 2'b10);
        good_entry();
        chk("post_lk_unlock", unlock, 1'b1);

        // reset during lockout
        bad_entry(); bad_entry(); bad_entry();
        chk("lk2_entered", {fail, locked}, 2'b11);
        step(0, 4'h0); step(0, 4'h0);
        #2 rst = 1'b0;
        #1;
        chk("rst_lk_outs", {unlock, fail, locked, timeout}, 4'b0000);
        chk("rst_lk_cnt", digit_count, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 4'h1);
        chk("after_rst_first_key", {locked, digit_count}, {1'b0, 3'd1});
        step(1, 4'h2); step(1, 4'h3);
        chk("three_digits", digit_count, 3'd3);
        #2 rst = 1'b0;
        #1;
        chk("rst_entry_cnt", digit_count, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        good_entry();
        chk("after_rst_unlock", {unlock, fail, digit_count}, {2'b10, 3'd0});

`ifdef INACTIVITY_TIMEOUT_EN
        step(1, 4'h1);
        for (int c = 1; c < 100; c++) begin
            step(0, 4'h0);
            if (c == 99) chk("to_before", {timeout, digit_count}, {1'b0, 3'd1});
        end
        step(0, 4'h0);
        chk("to_pulse", {timeout, fail, digit_count}, {2'b10, 3'd0});
        step(0, 4'h0);
        chk("to_one_cycle", timeout, 1'b0);
        step(1, 4'h1);
        for (int c = 1; c < 100; c++) step(0, 4'h0);
        step(1, 4'h2);
        chk("to_key_wins", {timeout, digit_count}, {1'b0, 3'd2});
        for (int c = 1; c < 100; c++) step(0, 4'h0);
        chk("to_restarted", {timeout, digit_count}, {1'b0, 3'd2});
        step(0, 4'h0);
        chk("to_second", {timeout, digit_count}, {1'b1, 3'd0});
`else
        step(1, 4'h1);
        for (int c = 0; c < 150; c++) step(0, 4'h0);
        chk("no_timeout", {timeout, digit_count}, {1'b0, 3'd1});
        step(1, 4'hC);
`endif
        good_entry();
        chk("final_unlock", unlock, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/controlador_de_senha.md
# controlador_de_senha

PIN-entry controller sitting downstream of `decodificador_de_teclado`. It consumes the decoder's one-cycle key events and assembles digits into an entry buffer, with backspace, clear and confirm keys. On confirm it compares the buffer against a reference PIN and issues an unlock or fail pulse. It counts consecutive failures and enforces a timed lockout, giving the keypad path a complete access-control sequencer.

## Interface
- `PIN_LEN`, 4: number of digits in a PIN (1..8).
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_CYC`, 5000: lockout duration in clk cycles (≥2).
- `TIMEOUT_CYC`, 1000: inactivity limit in clk cycles; used only with `INACTIVITY_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tecla_valid`  in  1  one-cycle key event strobe from the decoder.
- `tecla_value`  in  4  key code, sampled when `tecla_valid`=1.
- `pin_ref`  in  4*PIN_LEN  reference PIN, BCD; first digit in the most-significant nibble; sampled only in CHECK.
- `unlock`  out  1  one-cycle pulse on correct PIN.
- `fail`  out  1  one-cycle pulse on wrong PIN.
- `locked`  out  1  level, high during LOCKOUT.
- `timeout`  out  1  one-cycle pulse when the entry is abandoned.
- `digit_count`  out  $clog2(PIN_LEN+1)  digits currently held in the buffer.

## Operation
- Key classes: 0x0–0x9 digit; 0xA confirm; 0xB backspace; 0xC clear; 0xD–0xF ignored in every state.
- States: IDLE, ENTRY, CHECK, LOCKOUT.
- IDLE (`digit_count`=0):
  - A digit is stored at nibble 0, count becomes 1, state moves to ENTRY.
  - A, B and C are ignored.
- ENTRY:
  - Digit with count<PIN_LEN: stored at nibble `count`, count increments.
  - Digit with count=PIN_LEN: ignored; buffer unchanged.
  - B: count decrements. When count reaches 0, state moves to IDLE.
  - C: count set to 0, state moves to IDLE.
  - A: state moves to CHECK.
- CHECK (exactly one cycle; keys arriving in this cycle are dropped):
  - Match condition: count=PIN_LEN and buffer equals `pin_ref`. A short entry is a mismatch.
  - Match: `unlock` pulses, fail counter clears, state moves to IDLE.
  - Mismatch: `fail` pulses and the fail counter increments. If the counter reaches MAX_FAIL, state moves to LOCKOUT; otherwise it moves to IDLE.
  - The buffer and `digit_count` clear in both cases.
- LOCKOUT:
  - `locked`=1 and all keys are ignored.
  - After LOCKOUT_CYC cycles, state moves to IDLE and the fail counter clears.
- Fail counter width is $clog2(MAX_FAIL+1). It saturates at MAX_FAIL and never wraps.

## Timing
- Reset values: state IDLE, `unlock`=0, `fail`=0, `locked`=0, `timeout`=0, `digit_count`=0, buffer 0, all counters 0.
- Reset asserted mid-entry or mid-lockout aborts immediately (asynchronous). The first key is accepted on the first rising edge after `rst` deasserts.
- `digit_count` updates on the same edge that samples the key: a key sampled at edge N is visible after N.
- Confirm A sampled at edge N: CHECK holds from N to N+1. `unlock` or `fail` is high from N+1 to N+2.
- `locked` rises on the same edge as the final `fail` pulse. It stays high for exactly LOCKOUT_CYC cycles.
- A key arriving on the edge where LOCKOUT ends is ignored.
- `unlock` and `fail` are never high together. At most one pulse occurs per confirm.

## Configuration
- Macro: `INACTIVITY_TIMEOUT_EN`.
- Defined:
  - In ENTRY, a cycle counter resets on every accepted or ignored key event (any `tecla_valid`).
  - When the counter reaches TIMEOUT_CYC, the buffer clears, `digit_count` goes to 0, state moves to IDLE and `timeout` pulses for one cycle. The fail counter is unchanged.
  - If a key and expiry coincide on the same edge, the key wins and the counter restarts.
- Undefined: no timer logic, `timeout` is tied to 0, and ENTRY persists indefinitely.

## Test plan
Bench settings: PIN_LEN=4, MAX_FAIL=3, LOCKOUT_CYC=50, TIMEOUT_CYC=100, `pin_ref`=16'h1234.

- Keys 1,2,3,4,A → `unlock` pulses 2 cycles after the A strobe; `fail` stays 0; `digit_count` returns to 0.
- Keys 1,2,9,B,3,4,A → `digit_count` sequence 1,2,3,2,3,4 then `unlock`. Then 1,2,3,4,5,A → the 5 is ignored (count stays 4) and `unlock` pulses.
- Three entries of 1,2,3,A (short entry) → `fail` pulses three times; `locked` rises with the third `fail` and holds 50 cycles. Key 1 during lockout → `digit_count` stays 0.
- Keys 1,2,C then A → C clears the entry (count 0, IDLE) and the following A is ignored in IDLE: no pulse. Keys D,E,F in any state → no state change.
- With `INACTIVITY_TIMEOUT_EN`: key 1, then idle 100 cycles → `timeout` pulse, count 0, no `fail`. A key on the expiry edge → no `timeout`.
- `rst` low during LOCKOUT and again with 3 digits entered → all outputs at reset values immediately. Afterwards 1,2,3,4,A → `unlock`.
